// File: rtl/csr_trap_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit_pkg
// Purpose  : Shared constants for the machine-mode CSR file / trap sequencer:
//            CSR addresses, mcause codes, FSM encodings, exception flag bit
//            positions (also used by decode) and the CSR read-modify-write
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csr_trap_unit_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    // mcause codes
    localparam logic [31:0] MCAUSE_ECALL_M  = 32'd11;
    localparam logic [31:0] MCAUSE_MEXT_IRQ = 32'h8000_000B;

    // Trap sequencer state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TRAP = 2'd1;
    localparam logic [1:0] ST_MRET = 2'd2;

    // Bit positions inside the exception flag word carried from decode
    localparam int EXC_MRET  = 0;
    localparam int EXC_ECALL = 1;

    // CSRRW/CSRRS/CSRRC new-value computation; op is funct3[1:0].
    // The immediate forms share this datapath, op 00 leaves the value as is.
    function automatic logic [31:0] csr_rmw(
        input logic [31:0] old_val,
        input logic [31:0] src,
        input logic [1:0]  op
    );
        case (op)
            2'b01:   return src;
            2'b10:   return old_val | src;
            2'b11:   return old_val & ~src;
            default: return old_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter64
// Purpose  : 64-bit free-running cycle counter with independently writable
//            halves. A write in a cycle replaces the increment; the half that
//            is not written holds its value (no carry from the write).
// Ports    : i_clk, i_rst_n (async, active-low), i_we_lo / i_we_hi (half
//            write enables), i_wdata (write data), o_count (counter value)
// Revision : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;
    logic [63:0] w_inc;
    logic [31:0] w_next_lo;
    logic [31:0] w_next_hi;

    assign w_inc = r_count + 64'd1;

    // Any write freezes the other half so no carry crosses the boundary
    // in the cycle of a software write.
    assign w_next_lo = i_we_lo ? i_wdata :
                       (i_we_hi ? r_count[31:0]  : w_inc[31:0]);
    assign w_next_hi = i_we_hi ? i_wdata :
                       (i_we_lo ? r_count[63:32] : w_inc[63:32]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 64'd0;
        end else begin
            r_count <= {w_next_hi, w_next_lo};
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : EXE-stage machine-mode CSR file and trap sequencer. Executes
//            CSRRW/S/C(I), takes ecall / external-interrupt traps, executes
//            mret, and issues pipeline flush plus PC redirect.
// Ports    : clk_i, rst_i (async, active-low); valid_i, inst_addr_i,
//            exception_i ({ecall, mret}), csr_we_i, csr_addr_i, csr_funct3_i,
//            csr_src_i, irq_i; csr_rdata_o (old CSR value, combinational),
//            flush_o, redirect_o, redirect_addr_o
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] exception_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [2:0]  csr_funct3_i,
    input  logic [31:0] csr_src_i,
    input  logic        irq_i,
    output logic [31:0] csr_rdata_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_meie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] w_mcycle;

    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_idle;
    logic        w_ecall;
    logic        w_mret;
    logic        w_irq_pend;
    logic        w_take_trap;
    logic        w_take_mret;
    logic        w_csr_wr;
    logic        w_unused_bits;

    // Upper exception flags and the zimm select bit carry no information here.
    assign w_unused_bits = ^{exception_i[31:2], csr_funct3_i[2]};

    // ---------------- CSR read mux (value before the edge) ----------------
    always_comb begin
        w_old = 32'd0;
        case (csr_addr_i)
            CSR_MSTATUS:  w_old = {19'd0, 2'b11, 3'd0, r_mstatus_mpie,
                                   3'd0, r_mstatus_mie, 3'd0};
            CSR_MIE:      w_old = {20'd0, r_mie_meie, 11'd0};
            CSR_MTVEC:    w_old = r_mtvec;
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC:     w_old = r_mepc;
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MIP:      w_old = {20'd0, irq_i, 11'd0};
            CSR_MCYCLE:   w_old = w_mcycle[31:0];
            CSR_MCYCLEH:  w_old = w_mcycle[63:32];
            default:      w_old = 32'd0;
        endcase
    end

    assign csr_rdata_o = w_old;
    assign w_new       = csr_rmw(w_old, csr_src_i, csr_funct3_i[1:0]);

    // ---------------- Trap / return detection ----------------
    // Gating with rst_i keeps flush_o low while reset is held.
    assign w_idle      = rst_i & (r_state == ST_IDLE);
    assign w_ecall     = valid_i & exception_i[EXC_ECALL];
    assign w_mret      = valid_i & exception_i[EXC_MRET];
    assign w_irq_pend  = irq_i & r_mie_meie & r_mstatus_mie;
    assign w_take_trap = w_idle & (w_ecall | (valid_i & w_irq_pend));
    assign w_take_mret = w_idle & w_mret & ~w_take_trap;
    // A trapping instruction is abandoned, so its CSR write never commits.
    assign w_csr_wr    = w_idle & valid_i & csr_we_i & ~w_take_trap &
                         (csr_funct3_i[1:0] != 2'b00);

    // ---------------- CSR registers ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mtvec        <= {MTVEC_RESET[31:2], 2'b00};
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
        end else begin
            if (w_csr_wr) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        r_mstatus_mie  <= w_new[3];
                        r_mstatus_mpie <= w_new[7];
                    end
                    CSR_MIE:      r_mie_meie <= w_new[11];
                    CSR_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    default: ;
                endcase
            end
            // Placed after the CSR write so the trap-side mstatus update wins.
            if (w_take_trap) begin
                r_mepc         <= {inst_addr_i[31:2], 2'b00};
                r_mcause       <= w_ecall ? MCAUSE_ECALL_M : MCAUSE_MEXT_IRQ;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_take_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    csr_counter64 u_mcycle (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_we_lo (w_csr_wr & (csr_addr_i == CSR_MCYCLE)),
        .i_we_hi (w_csr_wr & (csr_addr_i == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_count (w_mcycle)
    );

    // ---------------- Trap sequencer FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_take_trap) begin
                    w_state_next = ST_TRAP;
                end else if (w_take_mret) begin
                    w_state_next = ST_MRET;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TRAP: w_state_next = ST_IDLE;
            ST_MRET: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_o         = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = 32'd0;
        case (r_state)
            ST_IDLE: flush_o = w_take_trap | w_take_mret;
            ST_TRAP: begin
                redirect_o      = 1'b1;
                redirect_addr_o = r_mtvec;
            end
            ST_MRET: begin
                redirect_o      = 1'b1;
                redirect_addr_o = r_mepc;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Purpose  : Self-checking bench for csr_trap_unit: directed scenarios plus
//            randomized traffic compared against a behavioural CSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] inst_addr_i;
    logic [31:0] exception_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [2:0]  csr_funct3_i;
    logic [31:0] csr_src_i;
    logic        irq_i;
    logic [31:0] csr_rdata_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;

    csr_trap_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .inst_addr_i     (inst_addr_i),
        .exception_i     (exception_i),
        .csr_we_i        (csr_we_i),
        .csr_addr_i      (csr_addr_i),
        .csr_funct3_i    (csr_funct3_i),
        .csr_src_i       (csr_src_i),
        .irq_i           (irq_i),
        .csr_rdata_o     (csr_rdata_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model of the architectural state
    bit          m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle;
    int          m_pend;   // 0: none, 1: redirect to mtvec, 2: redirect to mepc

    // Values sampled in the last step
    logic [31:0] s_rdata, s_raddr;
    logic        s_flush, s_redir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, input logic irq);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return 32'(irq) << 11;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0;
        m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_cycle = 0; m_pend = 0;
    endtask

    // Entered and left at a falling edge; reset asserted asynchronously.
    task automatic reset_dut();
        rst_i = 1'b0;
        valid_i = 1'b1; exception_i = 32'h2; csr_we_i = 1'b0;
        #1;
        chk("rst_redirect", 32'(redirect_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_raddr", redirect_addr_o, 32'd0);
        model_reset();
        @(negedge clk_i);
        chk("rst_hold_redirect", 32'(redirect_o), 32'd0);
        chk("rst_hold_flush", 32'(flush_o), 32'd0);
        valid_i = 1'b0; exception_i = 32'd0;
        rst_i = 1'b1;
    endtask

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] exc,
                        input logic we, input logic [11:0] addr, input logic [2:0] f3,
                        input logic [31:0] src, input logic irq);
        logic        ecall, irqp, trap, ret, wr, cyc_wr;
        logic [31:0] oldv, nv, e_raddr;
        valid_i = v; inst_addr_i = pc; exception_i = exc; csr_we_i = we;
        csr_addr_i = addr; csr_funct3_i = f3; csr_src_i = src; irq_i = irq;
        #1;
        ecall = v & exc[1];
        irqp  = irq & m_meie & m_mie;
        trap  = (m_pend == 0) && v && (ecall || irqp);
        ret   = (m_pend == 0) && v && exc[0] && !trap;
        e_raddr = (m_pend == 1) ? m_mtvec : ((m_pend == 2) ? m_mepc : 32'd0);
        oldv = m_read(addr, irq);
        chk("rdata", csr_rdata_o, oldv);
        chk("flush", 32'(flush_o), 32'(trap | ret));
        chk("redirect", 32'(redirect_o), 32'(m_pend != 0));
        chk("redirect_addr", redirect_addr_o, e_raddr);
        s_rdata = csr_rdata_o; s_flush = flush_o;
        s_redir = redirect_o;  s_raddr = redirect_addr_o;
        @(posedge clk_i);
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = oldv | src;
            2'b11:   nv = oldv & ~src;
            default: nv = oldv;
        endcase
        cyc_wr = 0;
        if (m_pend != 0) begin
            m_pend = 0;
        end else begin
            wr = v && we && !trap && (f3[1:0] != 2'b00);
            if (wr) begin
                case (addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_meie = nv[11];
                    12'h305: m_mtvec = nv & ~32'h3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'hB00: begin m_cycle[31:0]  = nv; cyc_wr = 1; end
                    12'hB80: begin m_cycle[63:32] = nv; cyc_wr = 1; end
                    default: ;
                endcase
            end
            if (trap) begin
                m_mepc   = pc & ~32'h3;
                m_mcause = ecall ? 32'd11 : 32'h8000_000B;
                m_mpie   = m_mie;
                m_mie    = 0;
                m_pend   = 1;
            end else if (ret) begin
                m_mie  = m_mpie;
                m_mpie = 1;
                m_pend = 2;
            end
        end
        if (!cyc_wr) m_cycle = m_cycle + 64'd1;
        @(negedge clk_i);
    endtask

    task automatic step_rd(input logic [11:0] addr);
        step(1'b0, 32'd0, 32'd0, 1'b0, addr, 3'b000, 32'd0, 1'b0);
    endtask

    task automatic bubble();
        step(1'b0, 32'd0, 32'd0, 1'b0, 12'h000, 3'b000, 32'd0, 1'b0);
    endtask

    logic [11:0] addr_tbl [0:10];
    logic [31:0] h0, rv, exc_r;
    int          k;

    initial begin
        addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h001};
        rst_i = 1'b0; valid_i = 0; inst_addr_i = 0; exception_i = 0;
        csr_we_i = 0; csr_addr_i = 0; csr_funct3_i = 0; csr_src_i = 0; irq_i = 0;
        @(negedge clk_i);
        reset_dut();

        step_rd(12'h305);
        chk("mtvec_reset", s_rdata, 32'h0000_0100);

        // CSRRW then CSRRS on mscratch
        step(1, 32'h10, 0, 1, 12'h340, 3'b001, 32'hDEAD_BEEF, 0);
        chk("csrrw_old", s_rdata, 32'd0);
        step(1, 32'h14, 0, 1, 12'h340, 3'b010, 32'd0, 0);
        chk("csrrs_read", s_rdata, 32'hDEAD_BEEF);

        // Set then clear MIE
        step(1, 32'h18, 0, 1, 12'h300, 3'b110, 32'd8, 0);
        step(1, 32'h1C, 0, 1, 12'h300, 3'b011, 32'd8, 0);
        chk("mstatus_mie_set", s_rdata, 32'h0000_1808);
        step_rd(12'h300);
        chk("mstatus_mie_clr", s_rdata, 32'h0000_1800);

        // ecall with MIE = 1
        step(1, 32'h20, 0, 1, 12'h300, 3'b010, 32'd8, 0);
        step(1, 32'h40, 32'h2, 0, 12'h000, 3'b000, 32'd0, 0);
        chk("ecall_flush", 32'(s_flush), 32'd1);
        chk("ecall_no_redir", 32'(s_redir), 32'd0);
        bubble();
        chk("trap_redir", 32'(s_redir), 32'd1);
        chk("trap_target", s_raddr, 32'h0000_0100);
        step_rd(12'h341);
        chk("ecall_mepc", s_rdata, 32'h40);
        step_rd(12'h342);
        chk("ecall_mcause", s_rdata, 32'd11);
        step_rd(12'h300);
        chk("ecall_mstatus", s_rdata, 32'h0000_1880);

        // mret
        step(1, 32'h100, 32'h1, 0, 12'h000, 3'b000, 32'd0, 0);
        chk("mret_flush", 32'(s_flush), 32'd1);
        bubble();
        chk("mret_redir", 32'(s_redir), 32'd1);
        chk("mret_target", s_raddr, 32'h40);
        step_rd(12'h300);
        chk("mret_mstatus", s_rdata, 32'h0000_1888);

        // External interrupt abandons a CSRRW to mscratch
        step(1, 32'h104, 0, 1, 12'h304, 3'b001, 32'h800, 0);
        step(1, 32'h200, 0, 1, 12'h340, 3'b001, 32'h1234, 1);
        chk("irq_flush", 32'(s_flush), 32'd1);
        step(0, 32'd0, 0, 0, 12'h000, 3'b000, 32'd0, 1);
        chk("irq_target", s_raddr, 32'h0000_0100);
        step_rd(12'h340);
        chk("irq_mscratch_kept", s_rdata, 32'hDEAD_BEEF);
        step_rd(12'h342);
        chk("irq_mcause", s_rdata, 32'h8000_000B);
        step_rd(12'h341);
        chk("irq_mepc", s_rdata, 32'h200);
        // MIE now 0: the same request is not taken
        step(1, 32'h204, 0, 1, 12'h340, 3'b001, 32'h1234, 1);
        chk("irq_masked_flush", 32'(s_flush), 32'd0);
        step_rd(12'h340);
        chk("irq_masked_write", s_rdata, 32'h1234);

        // mcycle rollover into mcycleh
        step_rd(12'hB80);
        h0 = s_rdata;
        step(1, 32'h208, 0, 1, 12'hB00, 3'b001, 32'hFFFF_FFFF, 0);
        step_rd(12'hB00);
        chk("mcycle_written", s_rdata, 32'hFFFF_FFFF);
        step_rd(12'hB00);
        chk("mcycle_wrap", s_rdata, 32'd0);
        step_rd(12'hB80);
        chk("mcycleh_carry", s_rdata, h0 + 32'd1);

        // Reset in the TRAP cycle
        step(1, 32'h300, 32'h2, 0, 12'h000, 3'b000, 32'd0, 0);
        reset_dut();
        step_rd(12'h340);
        chk("rst_mscratch", s_rdata, 32'd0);
        chk("rst_no_redir", 32'(s_redir), 32'd0);
        step_rd(12'h300);
        chk("rst_mstatus", s_rdata, 32'h0000_1800);
        step_rd(12'h341);
        chk("rst_mepc", s_rdata, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       v, we, irq;
            logic [2:0] f3;
            logic [31:0] src;
            rv    = $urandom;
            v     = rv[0] | rv[1];
            exc_r = $urandom;
            k     = $urandom_range(0, 19);
            exc_r[1] = (k == 0);
            exc_r[0] = (k == 1) || (k == 2);
            we    = ($urandom_range(0, 1) == 1) && !exc_r[0];
            f3    = 3'($urandom_range(0, 7));
            src   = rv[2] ? $urandom : 32'($urandom_range(0, 15) << 3 | 32'h800);
            irq   = ($urandom_range(0, 3) == 0);
            step(v, $urandom, exc_r, we, addr_tbl[$urandom_range(0, 10)], f3, src, irq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
